// File: rtl/apb_reg_slave.sv
// APB completer with a NUM_REGS x 32-bit register bank and FSM-counted wait states.
// Optional macro APB_SLV_ERR_EN: invalid-address transfers complete with slverr=1.
module apb_reg_slave #(
    parameter logic [2:0] SLAVE_ID    = 3'd1,
    parameter int         NUM_REGS    = 16,
    parameter int         WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  sel_port,
    input  logic        en,
    input  logic        wr_out,
    input  logic [11:0] addr_out,
    input  logic [31:0] data_out,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        slverr
);

    localparam int         IDX_W = $clog2(NUM_REGS);
    localparam logic [8:0] LIMIT = 9'(NUM_REGS * 4);
`ifdef APB_SLV_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t             state, state_next;
    logic [3:0]         cnt, cnt_next;
    logic               ready_next;
    logic [31:0]        rdata_next;
    logic               err_q, err_next;
    logic               capture, commit;
    logic               cap_wr;
    logic [7:0]         cap_off;
    logic [31:0]        cap_data;
    logic               selected;
    logic               addr_bad;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        regs [NUM_REGS];
    logic               unused_addr_hi;

    assign selected       = (sel_port == SLAVE_ID);
    assign idx            = cap_off[IDX_W+1:2];
    assign addr_bad       = ({1'b0, cap_off} >= LIMIT) || (cap_off[1:0] != 2'b00);
    assign unused_addr_hi = ^addr_out[11:8];
    assign slverr         = ERR_EN ? err_q : 1'b0;

    // Losing select or enable in WAIT/DONE abandons the transfer without touching the bank.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ready_next = ready;
        rdata_next = rdata;
        err_next   = err_q;
        capture    = 1'b0;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (selected && !en) begin
                    capture    = 1'b1;
                    cnt_next   = 4'(WAIT_CYCLES);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (!(selected && en)) begin
                    state_next = IDLE;
                    ready_next = 1'b0;
                end else if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    state_next = DONE;
                    ready_next = 1'b1;
                    rdata_next = (!cap_wr && !addr_bad) ? regs[idx] : 32'd0;
                    err_next   = ERR_EN && addr_bad;
                end
            end
            DONE: begin
                commit     = selected && en && cap_wr && !addr_bad;
                state_next = IDLE;
                ready_next = 1'b0;
                rdata_next = 32'd0;
                err_next   = 1'b0;
            end
            default: begin
                state_next = IDLE;
                ready_next = 1'b0;
                rdata_next = 32'd0;
                err_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            ready <= 1'b0;
            rdata <= 32'd0;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ready <= ready_next;
            rdata <= rdata_next;
            err_q <= err_next;
        end
    end

    // Setup-phase request is latched so the access phase may not rely on the bus holding it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_wr   <= 1'b0;
            cap_off  <= 8'd0;
            cap_data <= 32'd0;
        end else if (capture) begin
            cap_wr   <= wr_out;
            cap_off  <= addr_out[7:0];
            cap_data <= data_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'd0;
        end else if (commit) begin
            regs[idx] <= cap_data;
        end
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Self-checking bench for apb_reg_slave: two instances (2 and 0 wait states) on one APB bus.
// A transfer-level model predicts ready/rdata/slverr every cycle from latency and address rules.
module tb_apb_reg_slave;

    localparam int W1 = 2;
    localparam int W2 = 0;
`ifdef APB_SLV_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  sel_port;
    logic        en;
    logic        wr_out;
    logic [11:0] addr_out;
    logic [31:0] data_out;
    logic        ready1, slverr1, ready2, slverr2;
    logic [31:0] rdata1, rdata2;

    int checks = 0;
    int passes = 0;

    logic [31:0] model1 [16];
    logic [31:0] model2 [16];
    logic        exp_ready1, exp_err1, exp_ready2, exp_err2;
    logic [31:0] exp_rdata1, exp_rdata2;

    int          obs_k;
    logic [31:0] obs_rdata;
    logic        obs_err;

    always #5 clk = ~clk;

    apb_reg_slave #(.SLAVE_ID(3'd1), .NUM_REGS(16), .WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .rst(rst), .sel_port(sel_port), .en(en), .wr_out(wr_out),
        .addr_out(addr_out), .data_out(data_out),
        .ready(ready1), .rdata(rdata1), .slverr(slverr1)
    );

    apb_reg_slave #(.SLAVE_ID(3'd5), .NUM_REGS(16), .WAIT_CYCLES(W2)) dut2 (
        .clk(clk), .rst(rst), .sel_port(sel_port), .en(en), .wr_out(wr_out),
        .addr_out(addr_out), .data_out(data_out),
        .ready(ready2), .rdata(rdata2), .slverr(slverr2)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    endtask

    always @(negedge clk) begin
        check_output("ready1", 32'(ready1), 32'(exp_ready1));
        check_output("rdata1", rdata1, exp_rdata1);
        check_output("slverr1", 32'(slverr1), 32'(exp_err1));
        check_output("ready2", 32'(ready2), 32'(exp_ready2));
        check_output("rdata2", rdata2, exp_rdata2);
        check_output("slverr2", 32'(slverr2), 32'(exp_err2));
    end

    function automatic bit addr_valid(input logic [11:0] a);
        return (int'(a[7:0]) < 64) && (int'(a[7:0]) % 4 == 0);
    endfunction

    task automatic clear_exp();
        exp_ready1 = 1'b0; exp_rdata1 = 32'd0; exp_err1 = 1'b0;
        exp_ready2 = 1'b0; exp_rdata2 = 32'd0; exp_err2 = 1'b0;
    endtask

    task automatic clear_models();
        for (int i = 0; i < 16; i++) begin
            model1[i] = 32'd0;
            model2[i] = 32'd0;
        end
    endtask

    task automatic idle_cycles(input int n);
        sel_port = 3'd0;
        en       = 1'b0;
        clear_exp();
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One APB transfer; abort_after/rst_at select an access cycle for en-drop or reset (0 = never).
    task automatic apply_stimulus(input logic [2:0] sel, input logic wr, input logic [11:0] addr,
                                  input logic [31:0] data, input int abort_after, input int rst_at);
        int          tgt, lat, max_k, ix;
        bit          ok;
        logic [31:0] rd;
        tgt   = (sel == 3'd1) ? 1 : ((sel == 3'd5) ? 2 : 0);
        lat   = (tgt == 2) ? W2 + 2 : W1 + 2;
        max_k = (tgt == 0) ? 6 : lat;
        ok    = addr_valid(addr);
        ix    = int'(addr[7:0]) / 4;
        rd    = 32'd0;
        if (!wr && ok) rd = (tgt == 2) ? model2[ix % 16] : model1[ix % 16];
        obs_k = 0; obs_rdata = 32'd0; obs_err = 1'b0;

        sel_port = sel; en = 1'b0; wr_out = wr; addr_out = addr; data_out = data;
        clear_exp();
        @(posedge clk); #1;
        for (int k = 1; k <= max_k; k++) begin
            en = 1'b1;
            clear_exp();
            if (tgt == 1 && k == lat) begin
                exp_ready1 = 1'b1; exp_rdata1 = rd; exp_err1 = ERR_EN && !ok;
            end
            if (tgt == 2 && k == lat) begin
                exp_ready2 = 1'b1; exp_rdata2 = rd; exp_err2 = ERR_EN && !ok;
            end
            if (k == rst_at) begin
                #1;
                rst = 1'b1;
                clear_models();
                clear_exp();
                #1;
                check_output("ready1_async_rst", 32'(ready1), 32'd0);
                check_output("ready2_async_rst", 32'(ready2), 32'd0);
                @(posedge clk); #1;
                rst = 1'b0; sel_port = 3'd0; en = 1'b0;
                @(posedge clk); #1;
                return;
            end
            #3;
            if (obs_k == 0) begin
                if (tgt == 2 && ready2) begin obs_k = k; obs_rdata = rdata2; obs_err = slverr2; end
                if (tgt != 2 && ready1) begin obs_k = k; obs_rdata = rdata1; obs_err = slverr1; end
            end
            @(posedge clk); #1;
            if (tgt != 0 && k == lat) begin
                if (wr && ok) begin
                    if (tgt == 2) model2[ix] = data;
                    else          model1[ix] = data;
                end
                break;
            end
            if (k == abort_after) begin
                sel_port = 3'd0; en = 1'b0;
                clear_exp();
                @(posedge clk); #1;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1; sel_port = 3'd0; en = 1'b0; wr_out = 1'b0; addr_out = 12'd0; data_out = 32'd0;
        clear_models();
        clear_exp();
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_ready", 32'(ready1), 32'd0);
        check_output("reset_rdata", rdata1, 32'd0);
        check_output("reset_slverr", 32'(slverr1), 32'd0);
        rst = 1'b0;

        $display("[TB] reads of every register after reset");
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(3'd1, 1'b0, 12'h300 + 12'(i * 4), 32'd0, 0, 0);
            check_output("reset_read_zero", obs_rdata, 32'd0);
        end

        $display("[TB] basic write and read-back");
        apply_stimulus(3'd1, 1'b1, 12'h30C, 32'd13, 0, 0);
        check_output("write_latency", 32'(obs_k), 32'd4);
        apply_stimulus(3'd1, 1'b0, 12'h30C, 32'd0, 0, 0);
        check_output("read_latency", 32'(obs_k), 32'd4);
        check_output("read_0x30C", obs_rdata, 32'd13);
        apply_stimulus(3'd1, 1'b0, 12'hF0C, 32'd0, 0, 0);
        check_output("read_hi_bits_ignored", obs_rdata, 32'd13);

        $display("[TB] other slave selected");
        apply_stimulus(3'd2, 1'b1, 12'h304, 32'hDEAD, 0, 0);
        check_output("unselected_no_ready", 32'(obs_k), 32'd0);
        apply_stimulus(3'd1, 1'b0, 12'h304, 32'd0, 0, 0);
        check_output("read_0x304", obs_rdata, 32'd0);

        $display("[TB] invalid addresses");
        apply_stimulus(3'd1, 1'b1, 12'h340, 32'd5, 0, 0);
        check_output("bad_write_err", 32'(obs_err), 32'(ERR_EN));
        check_output("bad_write_latency", 32'(obs_k), 32'd4);
        apply_stimulus(3'd1, 1'b0, 12'h340, 32'd0, 0, 0);
        check_output("bad_read_zero", obs_rdata, 32'd0);
        check_output("bad_read_err", 32'(obs_err), 32'(ERR_EN));
        apply_stimulus(3'd1, 1'b1, 12'h302, 32'd77, 0, 0);
        apply_stimulus(3'd1, 1'b0, 12'h300, 32'd0, 0, 0);
        check_output("misaligned_dropped", obs_rdata, 32'd0);
        apply_stimulus(3'd1, 1'b0, 12'h30C, 32'd0, 0, 0);
        check_output("regs_unchanged", obs_rdata, 32'd13);

        $display("[TB] aborted write");
        apply_stimulus(3'd1, 1'b1, 12'h308, 32'd7, 1, 0);
        check_output("abort_no_ready", 32'(obs_k), 32'd0);
        apply_stimulus(3'd1, 1'b0, 12'h308, 32'd0, 0, 0);
        check_output("abort_no_update", obs_rdata, 32'd0);

        $display("[TB] back-to-back pattern fill");
        for (int i = 0; i < 16; i++)
            apply_stimulus(3'd1, 1'b1, 12'h300 + 12'(i * 4), 32'hA5000000 ^ (32'h01010101 * i), 0, 0);
        for (int i = 0; i < 16; i++)
            apply_stimulus(3'd1, 1'b0, 12'h300 + 12'(i * 4), 32'd0, 0, 0);
        apply_stimulus(3'd1, 1'b0, 12'h314, 32'd0, 0, 0);
        check_output("pattern_reg5", obs_rdata, 32'hA0050505);

        $display("[TB] reset in the middle of a write");
        apply_stimulus(3'd1, 1'b1, 12'h300, 32'd9, 0, 2);
        apply_stimulus(3'd1, 1'b0, 12'h300, 32'd0, 0, 0);
        check_output("after_rst_0x300", obs_rdata, 32'd0);
        apply_stimulus(3'd1, 1'b0, 12'h314, 32'd0, 0, 0);
        check_output("after_rst_cleared", obs_rdata, 32'd0);

        $display("[TB] zero wait-state slave");
        apply_stimulus(3'd5, 1'b1, 12'h30C, 32'd13, 0, 0);
        check_output("w0_write_latency", 32'(obs_k), 32'd2);
        apply_stimulus(3'd5, 1'b0, 12'h30C, 32'd0, 0, 0);
        check_output("w0_read_latency", 32'(obs_k), 32'd2);
        check_output("w0_read_data", obs_rdata, 32'd13);
        apply_stimulus(3'd1, 1'b0, 12'h30C, 32'd0, 0, 0);
        check_output("w0_isolated", obs_rdata, 32'd0);
        apply_stimulus(3'd5, 1'b1, 12'h310, 32'h55, 0, 2);
        apply_stimulus(3'd5, 1'b0, 12'h310, 32'd0, 0, 0);
        check_output("w0_rst_in_ready", obs_rdata, 32'd0);

        idle_cycles(3);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
